// File: rtl/tag_lookup_ctrl.sv
// Set-associative tag/valid store with lookup FSM; drives the command port of the
// downstream per-set LRU age array (init after reset, one touch per completed lookup).
module tag_lookup_ctrl #(
    parameter int ASSOC      = 8,
    parameter int INDEX_SIZE = 7,
    parameter int TAG_SIZE   = 19
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [INDEX_SIZE-1:0]    req_index,
    input  logic [TAG_SIZE-1:0]      req_tag,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic                     resp_hit,
    output logic [$clog2(ASSOC)-1:0] resp_way,
    output logic                     resp_evict,
    output logic [TAG_SIZE-1:0]      resp_evict_tag,
    output logic [1:0]               lru_replace,
    output logic [INDEX_SIZE-1:0]    lru_index,
    output logic [$clog2(ASSOC)-1:0] lru_assoc,
    input  logic [$clog2(ASSOC)-1:0] lru_way
);

    localparam int WAY_W = $clog2(ASSOC);
    localparam int SETS  = 2 ** INDEX_SIZE;

    typedef enum logic [1:0] {INIT, IDLE, LOOKUP, RESP} state_t;

    state_t                state_q, state_d;
    logic [INDEX_SIZE-1:0] idx_q, idx_d;
    logic [TAG_SIZE-1:0]   tag_q, tag_d;
    logic                  hit_q, hit_d;
    logic [WAY_W-1:0]      way_q, way_d;
    logic                  evict_q, evict_d;
    logic [TAG_SIZE-1:0]   etag_q, etag_d;
    logic [WAY_W-1:0]      assoc_q, assoc_d;

    logic [ASSOC-1:0]      valid_q [SETS];
    logic [TAG_SIZE-1:0]   tags_q  [SETS][ASSOC];

    logic                  hit;
    logic [WAY_W-1:0]      hit_way;
    logic                  any_inv;
    logic [WAY_W-1:0]      inv_way;
    logic [WAY_W-1:0]      victim;
    logic [WAY_W-1:0]      touch_way;
    logic                  alloc;

    // Lowest matching way and lowest invalid way win.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        any_inv = 1'b0;
        inv_way = '0;
        for (int unsigned w = 0; w < ASSOC; w++) begin
            if (!hit && valid_q[idx_q][w] && (tags_q[idx_q][w] == tag_q)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!any_inv && !valid_q[idx_q][w]) begin
                any_inv = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
        victim    = any_inv ? inv_way : lru_way;
        touch_way = hit ? hit_way : victim;
        alloc     = (state_q == LOOKUP) && !hit;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tag_d   = tag_q;
        hit_d   = hit_q;
        way_d   = way_q;
        evict_d = evict_q;
        etag_d  = etag_q;
        assoc_d = assoc_q;
        case (state_q)
            INIT: state_d = IDLE;
            IDLE: begin
                if (req_valid) begin
                    idx_d   = req_index;
                    tag_d   = req_tag;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                hit_d   = hit;
                way_d   = touch_way;
                evict_d = !hit && !any_inv;
                etag_d  = (!hit && !any_inv) ? tags_q[idx_q][victim] : '0;
                assoc_d = touch_way;
                state_d = RESP;
            end
            RESP: if (resp_ready) state_d = IDLE;
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            idx_q   <= '0;
            tag_q   <= '0;
            hit_q   <= 1'b0;
            way_q   <= '0;
            evict_q <= 1'b0;
            etag_q  <= '0;
            assoc_q <= '0;
            for (int unsigned s = 0; s < SETS; s++) valid_q[s] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tag_q   <= tag_d;
            hit_q   <= hit_d;
            way_q   <= way_d;
            evict_q <= evict_d;
            etag_q  <= etag_d;
            assoc_q <= assoc_d;
            if (alloc) valid_q[idx_q][victim] <= 1'b1;
        end
    end

    // Tag contents need no reset; the cleared valid bits mask them.
    always_ff @(posedge clk) begin
        if (alloc) tags_q[idx_q][victim] <= tag_q;
    end

    // rst gating keeps the reset value 11 and suppresses the touch of an aborted lookup.
    always_comb begin
        if (rst)                   lru_replace = 2'b11;
        else if (state_q == INIT)  lru_replace = 2'b00;
        else if (state_q == LOOKUP) lru_replace = 2'b01;
        else                       lru_replace = 2'b11;
    end

    assign req_ready      = (state_q == IDLE);
    assign resp_valid     = (state_q == RESP);
    assign resp_hit       = hit_q;
    assign resp_way       = way_q;
    assign resp_evict     = evict_q;
    assign resp_evict_tag = etag_q;
    assign lru_index      = idx_q;
    assign lru_assoc      = (state_q == LOOKUP) ? touch_way : assoc_q;

endmodule

// File: tb/tb_tag_lookup_ctrl.sv
// Directed bench for tag_lookup_ctrl: reset/init, cold fill, eviction, hits under
// back-pressure, set isolation and reset aborts.
module tb_tag_lookup_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [6:0]  req_index;
    logic [18:0] req_tag;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_hit;
    logic [2:0]  resp_way;
    logic        resp_evict;
    logic [18:0] resp_evict_tag;
    logic [1:0]  lru_replace;
    logic [6:0]  lru_index;
    logic [2:0]  lru_assoc;
    logic [2:0]  lru_way;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tag_lookup_ctrl #(.ASSOC(8), .INDEX_SIZE(7), .TAG_SIZE(19)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_index(req_index), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_hit(resp_hit), .resp_way(resp_way),
        .resp_evict(resp_evict), .resp_evict_tag(resp_evict_tag),
        .lru_replace(lru_replace), .lru_index(lru_index),
        .lru_assoc(lru_assoc), .lru_way(lru_way)
    );

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        check("req_ready_timeout", 32'(req_ready), 32'd1);
    endtask

    // Issue one request; inputs change at negedge, outputs sampled #1 later.
    task automatic do_req(input logic [6:0] idx, input logic [18:0] tag,
                          input logic exp_hit, input logic [2:0] exp_way,
                          input logic exp_evict, input logic [18:0] exp_etag,
                          input int hold);
        wait_ready();
        req_valid = 1'b1; req_index = idx; req_tag = tag;
        @(negedge clk); #1;
        req_valid = 1'b0;
        check("lookup_replace", 32'(lru_replace), 32'h1);
        check("lookup_index",   32'(lru_index), 32'(idx));
        check("lookup_assoc",   32'(lru_assoc), 32'(exp_way));
        check("lookup_no_resp", 32'(resp_valid), 32'd0);
        @(negedge clk); #1;
        check("resp_valid", 32'(resp_valid), 32'd1);
        for (int i = 0; i < hold; i++) begin
            check("hold_ready",   32'(req_ready), 32'd0);
            check("hold_replace", 32'(lru_replace), 32'h3);
            check("hold_valid",   32'(resp_valid), 32'd1);
            check("hold_way",     32'(resp_way), 32'(exp_way));
            @(negedge clk); #1;
        end
        check("resp_hit",   32'(resp_hit), 32'(exp_hit));
        check("resp_way",   32'(resp_way), 32'(exp_way));
        check("resp_evict", 32'(resp_evict), 32'(exp_evict));
        check("resp_etag",  32'(resp_evict_tag), 32'(exp_etag));
        check("resp_replace", 32'(lru_replace), 32'h3);
        resp_ready = 1'b1;
        @(negedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic release_and_check_init();
        rst = 1'b0;
        #1;
        check("init_replace", 32'(lru_replace), 32'h0);
        check("init_ready",   32'(req_ready), 32'd0);
        check("init_resp",    32'(resp_valid), 32'd0);
        @(negedge clk); #1;
        check("idle_ready",   32'(req_ready), 32'd1);
        check("idle_replace", 32'(lru_replace), 32'h3);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_index = '0; req_tag = '0;
        resp_ready = 1'b0; lru_way = '0;

        // 1. reset for two cycles
        @(negedge clk); #1;
        check("rst_replace", 32'(lru_replace), 32'h3);
        check("rst_ready",   32'(req_ready), 32'd0);
        check("rst_resp",    32'(resp_valid), 32'd0);
        check("rst_index",   32'(lru_index), 32'd0);
        check("rst_assoc",   32'(lru_assoc), 32'd0);
        check("rst_etag",    32'(resp_evict_tag), 32'd0);
        @(negedge clk);
        release_and_check_init();

        // 2. cold fill of set 5
        for (int w = 0; w < 8; w++)
            do_req(7'd5, 19'h100 + 19'(w), 1'b0, 3'(w), 1'b0, 19'h0, 0);

        // 3. eviction with the LRU array reporting way 0
        lru_way = 3'd0;
        do_req(7'd5, 19'h108, 1'b0, 3'd0, 1'b1, 19'h100, 0);
        do_req(7'd5, 19'h100, 1'b0, 3'd0, 1'b1, 19'h108, 0);
        do_req(7'd5, 19'h103, 1'b1, 3'd3, 1'b0, 19'h0, 0);

        // 4. hit held under back-pressure for five cycles
        do_req(7'd5, 19'h104, 1'b1, 3'd4, 1'b0, 19'h0, 5);

        // 5. same tag in another set, then set 5 unaffected
        do_req(7'd6, 19'h104, 1'b0, 3'd0, 1'b0, 19'h0, 0);
        do_req(7'd5, 19'h104, 1'b1, 3'd4, 1'b0, 19'h0, 0);
        lru_way = 3'd6;
        do_req(7'd5, 19'h200, 1'b0, 3'd6, 1'b1, 19'h106, 0);
        lru_way = 3'd0;

        // 6a. reset during LOOKUP
        wait_ready();
        req_valid = 1'b1; req_index = 7'd5; req_tag = 19'h101;
        @(negedge clk);
        req_valid = 1'b0; rst = 1'b1;
        #1;
        check("abort_lookup_no_touch", 32'(lru_replace), 32'h3);
        @(negedge clk);
        release_and_check_init();

        // 6b. reset during RESP
        wait_ready();
        req_valid = 1'b1; req_index = 7'd6; req_tag = 19'h104;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk); #1;
        check("pre_abort_resp", 32'(resp_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        release_and_check_init();

        // filled tags now all miss into empty sets
        do_req(7'd5, 19'h101, 1'b0, 3'd0, 1'b0, 19'h0, 0);
        do_req(7'd5, 19'h103, 1'b0, 3'd1, 1'b0, 19'h0, 0);
        do_req(7'd6, 19'h104, 1'b0, 3'd0, 1'b0, 19'h0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
